// File: rtl/la_pkg.sv
// Shared encodings for the logic-analyzer capture path: FSM states and trigger modes.
package la_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] TRIG_RISE  = 2'b00;
  localparam logic [1:0] TRIG_FALL  = 2'b01;
  localparam logic [1:0] TRIG_ANY   = 2'b10;
  localparam logic [1:0] TRIG_LEVEL = 2'b11;

endpackage

// File: rtl/trig_detect.sv
// Single-bit trigger from a now/prev sample pair, masked per channel.
// Purely combinational (zero latency); no flow control.
module trig_detect
  import la_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] now,
  input  logic [WIDTH-1:0] prev,
  output logic             hit
);

  logic [WIDTH-1:0] vec;

  always_comb begin
    vec = '0;
    case (mode)
      TRIG_RISE:  vec = ~prev & now;
      TRIG_FALL:  vec = prev & ~now;
      TRIG_ANY:   vec = prev ^ now;
      TRIG_LEVEL: vec = now;
      default:    vec = '0;
    endcase
    hit = |(vec & mask);
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: ring-buffer writes while armed, then post_count samples after trigger.
// Write strobe is combinational from state and tick; the RAM takes no backpressure.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [DIV_W-1:0]  div,
  input  logic [WIDTH-1:0]  now,
  input  logic [WIDTH-1:0]  prev,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W-1:0] trig_addr
);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  presc;
  logic [ADDR_W-1:0] rem;
  logic              trig_hit, trig, tick, active, start;

  trig_detect #(.WIDTH(WIDTH)) u_trig_detect (
    .mode (trig_mode),
    .mask (trig_mask),
    .now  (now),
    .prev (prev),
    .hit  (trig_hit)
  );

  assign active  = (state == ST_ARMED) || (state == ST_POST);
  assign trig    = (state == ST_ARMED) && trig_hit;
  // A trigger cycle is forced to be a tick so the trigger sample is always stored.
  assign tick    = active && (trig || (presc == div));
  assign start   = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign wr_data = now;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (arm) state_nxt = ST_ARMED;
        ST_ARMED: if (trig) state_nxt = (post_count == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (tick && (rem == ADDR_W'(1))) state_nxt = ST_DONE;
        ST_DONE:  if (arm) state_nxt = ST_ARMED;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en = tick;
    busy  = active;
    done  = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr   <= '0;
      presc     <= '0;
      wrapped   <= 1'b0;
      trig_addr <= '0;
      rem       <= '0;
    end else if (start) begin
      wr_addr <= '0;
      presc   <= '0;
      wrapped <= 1'b0;
    end else begin
      if (active) presc <= tick ? '0 : presc + 1'b1;
      if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
        if (wr_addr == '1) wrapped <= 1'b1;
      end
      if (trig) begin
        trig_addr <= wr_addr;
        rem       <= post_count;
      end else if ((state == ST_POST) && tick) begin
        rem <= rem - 1'b1;
      end
    end
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture sequencer for the logic analyzer. It watches the `now`/`prev` pair produced by the edge-safe input sampler, detects a programmable trigger, and drives a ring-buffer sample memory. The memory is written continuously while armed, then for a programmed number of post-trigger samples, and the block then stops. It sits between the sampler and the sample RAM; host-side registers drive its configuration inputs.

## Interface
Parameters:
- `WIDTH`, 8: probe channels; must match the sampler width.
- `ADDR_W`, 5: sample memory address width (depth `2**ADDR_W`).
- `DIV_W`, 8: sample-rate prescaler width.

Ports:
- `clk` in 1: single clock, shared with the sampler.
- `rst` in 1: synchronous, active-high reset.
- `arm` in 1: start a capture.
- `abort` in 1: cancel a capture; return to IDLE.
- `trig_mode` in 2: 00 rising, 01 falling, 10 any edge, 11 level-high.
- `trig_mask` in WIDTH: channels that participate in the trigger.
- `post_count` in ADDR_W: samples to store after the trigger sample.
- `div` in DIV_W: a sample tick occurs every `div+1` clocks.
- `now` in WIDTH: current sample from the sampler.
- `prev` in WIDTH: previous sample from the sampler.
- `wr_en` out 1: memory write strobe.
- `wr_addr` out ADDR_W: memory write address.
- `wr_data` out WIDTH: memory write data (equals `now`).
- `busy` out 1: high in ARMED or POST.
- `done` out 1: high in DONE.
- `wrapped` out 1: the ring has been fully written at least once in this capture.
- `trig_addr` out ADDR_W: address of the trigger sample.

## Operation
- States and transitions:
  - IDLE → ARMED on `arm`.
  - ARMED → POST on trigger.
  - ARMED → DONE on trigger when `post_count==0`.
  - POST → DONE when the final post sample is written.
  - DONE → ARMED on `arm`.
  - Any state → IDLE on `abort`.
- `abort` has priority over `arm`. `arm` is ignored in ARMED and POST.
- On entry to ARMED:
  - `wr_addr`, prescaler and `wrapped` clear to 0.
  - `trig_addr` keeps its old value until a new trigger.
- Trigger vector, evaluated every clock in ARMED:
  - rising: `~prev & now`
  - falling: `prev & ~now`
  - any edge: `prev ^ now`
  - level-high: `now`
- The trigger vector is ANDed with `trig_mask` and then OR-reduced to a single trigger bit. If `trig_mask==0`, the block never triggers; only `abort` exits.
- Sample tick:
  - The prescaler counts 0..`div`; a tick occurs at `div` (every clock when `div==0`).
  - A trigger cycle is always a tick and restarts the prescaler at 0.
- Writes:
  - `wr_en = tick & (ARMED | POST)`; `wr_data = now`.
  - After each write, `wr_addr` increments modulo `2**ADDR_W`.
  - `wrapped` sets when `wr_addr` wraps from max to 0.
- Trigger cycle:
  - The trigger sample is written at the current `wr_addr`, and that address is latched into `trig_addr`.
  - The remaining-sample counter loads `post_count`.
- POST:
  - Each tick writes and decrements the remaining counter.
  - The write that takes it to 0 moves the state to DONE on the next edge.
  - Because `post_count ≤ 2**ADDR_W-1`, the trigger sample is never overwritten.
- Oldest valid sample for readout: `wr_addr` if `wrapped`, else address 0.

## Timing
- Reset values:
  - state IDLE; `wr_en=0`, `wr_addr=0`, `busy=0`, `done=0`, `wrapped=0`, `trig_addr=0`.
  - Prescaler and remaining counter at 0.
  - `wr_data` follows `now`; it is 0 after the sampler's reset.
- `arm` sampled at edge N → ARMED from N+1; the first write occurs in cycle N+1 when `div==0`.
- `wr_en`/`wr_addr`/`wr_data` are valid in the same cycle. The memory captures them at the next edge.
- A trigger seen in cycle T gives its write in cycle T. The following cycle is POST, or DONE when `post_count==0`.
- With `div==0`, the last post write is in cycle T+`post_count` and `done` rises at T+`post_count`+1.
- `abort` in any cycle means `wr_en=0` from the next cycle on. The memory contents are left as-is.
- `rst` asserted mid-capture has the same effect as reset, with no partial-state retention.

## Structure
- Shared package `la_pkg`:
  - state encoding (`ST_IDLE`, `ST_ARMED`, `ST_POST`, `ST_DONE`)
  - `trig_mode` codes (`TRIG_RISE`, `TRIG_FALL`, `TRIG_ANY`, `TRIG_LEVEL`)
- One sub-module, `trig_detect`: purely combinational; inputs mode, mask, `now`, `prev`; output a single trigger bit. It can be reused by a future multi-stage trigger.
- The prescaler, address counter and FSM stay in `capture_ctrl`.

## Test plan
- Rising trigger:
  - Setup: `WIDTH=8`, `ADDR_W=5`, `div=0`, mask `0x01`, mode 00, `post_count=3`, arm.
  - Stimulus: `now[0]` rises while `wr_addr=6`.
  - Required: `trig_addr=6`; writes at 7, 8, 9; `done` one cycle after the write at 9; `busy` low.
- Wrap-around:
  - Stimulus: stay armed for 40 cycles, then trigger.
  - Required: `wrapped=1`; `wr_addr` sequence …31, 0, 1…; `trig_addr=8`.
- Prescaler:
  - Stimulus: `div=3`, armed, no trigger; then a trigger in the cycle after a tick.
  - Required: `wr_en` every 4th clock; the trigger cycle writes immediately and the next tick follows 4 clocks later.
- Boundary cases:
  - `post_count=0`: trigger → a single write, then DONE.
  - Mask 0: no trigger after 100 edges; `busy` stays high.
- Abort and reset:
  - `abort` and `arm` together in POST → IDLE with `wr_en=0` next cycle.
  - `rst` in POST → all outputs at reset values.
  - Re-arm from DONE → `wr_addr=0`, `wrapped=0`, `trig_addr` retained.
- Modes:
  - Falling, any-edge and level-high, each on channel 5 with mask `0x20`.
  - Required: edges on other channels are ignored; level-high triggers on the first cycle `now[5]=1` is seen while armed.
